// File: rtl/pps_div_regbank_pkg.sv
// rtl/pps_div_regbank_pkg.sv - shared channel map, commit codes and status bits for the PPS divider register bank
package pps_div_regbank_pkg;

  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h40;

  localparam logic [3:0] OFS_PER_TRUE = 4'd0;
  localparam logic [3:0] OFS_DIV_NUM  = 4'd1;
  localparam logic [3:0] OFS_PHASE    = 4'd2;
  localparam logic [3:0] OFS_WIDTH    = 4'd5;
  localparam logic [3:0] OFS_START    = 4'd6;
  localparam logic [3:0] OFS_STOP     = 4'd7;
  localparam logic [3:0] OFS_STATUS   = 4'd8;
  localparam logic [3:0] OFS_COMMIT   = 4'd9;

  localparam logic [7:0] CMD_DISARM = 8'h00;
  localparam logic [7:0] CMD_ARM    = 8'h01;
  localparam logic [7:0] CMD_NOW    = 8'h02;

  localparam int STS_PENDING = 0;
  localparam int STS_DIFF    = 1;

  typedef enum logic [1:0] {
    CMT_NONE,
    CMT_DISARM,
    CMT_ARM,
    CMT_NOW
  } commit_cmd_e;

  // Maps a channel offset to its index in the packed field array, or -1 if
  // the offset holds no configuration byte.
  function automatic int field_idx(input logic [3:0] ofs, input int phase_bytes);
    int idx;
    idx = -1;
    if (ofs < OFS_PHASE)
      idx = int'(ofs);
    else if (int'(ofs) < int'(OFS_PHASE) + phase_bytes)
      idx = int'(ofs);
    else if (ofs >= OFS_WIDTH && ofs <= OFS_STOP)
      idx = int'(ofs) - int'(OFS_WIDTH) + int'(OFS_PHASE) + phase_bytes;
    return idx;
  endfunction

endpackage

// File: rtl/pps_div_regbank_if.sv
// rtl/pps_div_regbank_if.sv - register bus between the decoder and the PPS divider register bank
interface pps_div_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();

  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_wr;
  logic                  i_rd;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_rd_valid;

  modport master (
    output i_addr, i_data, i_wr, i_rd,
    input  o_data, o_rd_valid
  );

  modport slave (
    input  i_addr, i_data, i_wr, i_rd,
    output o_data, o_rd_valid
  );

endinterface

// File: rtl/pps_div_chan_regs.sv
// rtl/pps_div_chan_regs.sv - one channel's shadow/active register sets with armed or immediate atomic commit
module pps_div_chan_regs
  import pps_div_regbank_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PHASE_BYTES = 3
) (
  input  logic                                    i_clk_10,
  input  logic                                    i_rst,
  input  logic                                    i_sel,
  input  logic                                    i_wr,
  input  logic [3:0]                              i_ofs,
  input  logic [DATA_WIDTH-1:0]                   i_data,
  input  logic                                    i_glob_arm,
  input  logic                                    i_pps_pulse,
  output logic [DATA_WIDTH-1:0]                   o_rdata,
  output logic [(5+PHASE_BYTES)*DATA_WIDTH-1:0]   o_active,
  output logic                                    o_cfg_update,
  output logic                                    o_pending
);

  localparam int NB = 5 + PHASE_BYTES;

  logic [DATA_WIDTH-1:0] shadow [NB];
  logic [DATA_WIDTH-1:0] active [NB];
  logic                  pending;
  logic                  differs;
  logic                  arm;
  logic                  commit;
  int                    fidx;
  commit_cmd_e           cmd;

  always_comb begin
    fidx = field_idx(i_ofs, PHASE_BYTES);
    cmd  = CMT_NONE;
    if (i_sel && i_wr && i_ofs == OFS_COMMIT) begin
      if (i_data == DATA_WIDTH'(CMD_DISARM))
        cmd = CMT_DISARM;
      else if (i_data == DATA_WIDTH'(CMD_ARM))
        cmd = CMT_ARM;
      else if (i_data == DATA_WIDTH'(CMD_NOW))
        cmd = CMT_NOW;
    end
    arm    = (cmd == CMT_ARM) || i_glob_arm;
    // A same-cycle arm or disarm overrides the PPS so the commit waits for the next one.
    commit = (cmd == CMT_NOW) ||
             (pending && i_pps_pulse && !arm && cmd != CMT_DISARM);
  end

  always_ff @(posedge i_clk_10) begin
    if (i_rst) begin
      for (int b = 0; b < NB; b++) begin
        shadow[b] <= '0;
        active[b] <= '0;
      end
      pending      <= 1'b0;
      o_cfg_update <= 1'b0;
    end else begin
      // Active captures the pre-write shadow when a write lands in the commit cycle.
      for (int b = 0; b < NB; b++) begin
        if (i_sel && i_wr && fidx == b)
          shadow[b] <= i_data;
        if (commit)
          active[b] <= shadow[b];
      end
      o_cfg_update <= commit;
      if (cmd == CMT_NOW)
        pending <= 1'b0;
      else if (arm)
        pending <= 1'b1;
      else if (cmd == CMT_DISARM || commit)
        pending <= 1'b0;
    end
  end

  always_comb begin
    differs = 1'b0;
    for (int b = 0; b < NB; b++)
      if (shadow[b] != active[b])
        differs = 1'b1;
  end

  always_comb begin
    o_rdata = '0;
    if (i_ofs == OFS_STATUS) begin
      o_rdata[STS_PENDING] = pending;
      o_rdata[STS_DIFF]    = differs;
    end else begin
      for (int b = 0; b < NB; b++)
        if (fidx == b)
          o_rdata = shadow[b];
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_pack
    assign o_active[b*DATA_WIDTH +: DATA_WIDTH] = active[b];
  end

  assign o_pending = pending;

endmodule

// File: rtl/pps_div_regbank.sv
// rtl/pps_div_regbank.sv - multi-channel PPS divider configuration bank: address decode, read mux, channel instances
module pps_div_regbank
  import pps_div_regbank_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int BASE_ADDR   = int'(DEFAULT_BASE_ADDR),
  parameter int CH_STRIDE   = 16,
  parameter int PHASE_BYTES = 3
) (
  input  logic                                  i_clk_10,
  input  logic                                  i_rst,
  pps_div_regbank_if.slave                      bus,
  input  logic                                  i_pps_pulse,
  output logic [N_CH*DATA_WIDTH-1:0]            o_periodic_true,
  output logic [N_CH*DATA_WIDTH-1:0]            o_div_number,
  output logic [N_CH*PHASE_BYTES*DATA_WIDTH-1:0] o_phase_us,
  output logic [N_CH*DATA_WIDTH-1:0]            o_width_us,
  output logic [N_CH*DATA_WIDTH-1:0]            o_start,
  output logic [N_CH*DATA_WIDTH-1:0]            o_stop,
  output logic [N_CH-1:0]                       o_cfg_update,
  output logic [N_CH-1:0]                       o_pending
);

  localparam int DW       = DATA_WIDTH;
  localparam int NB       = 5 + PHASE_BYTES;
  localparam int CH_SHIFT = $clog2(CH_STRIDE);

  int                 rel;
  int                 ch_int;
  int                 ofs_int;
  logic               ch_hit;
  logic               glob_hit;
  logic [3:0]         ofs;
  logic [N_CH-1:0]    sel;
  logic [N_CH-1:0]    glob_arm;
  logic [DW-1:0]      chan_rdata [N_CH];
  logic [NB*DW-1:0]   chan_active [N_CH];
  logic [DW-1:0]      rd_mux;
  logic               rd_go;

  // Only the low 16 offsets of each stride are mapped; the rest of the stride is reserved.
  always_comb begin
    rel      = int'(bus.i_addr) - BASE_ADDR;
    ch_int   = rel >>> CH_SHIFT;
    ofs_int  = rel & (CH_STRIDE - 1);
    ch_hit   = (rel >= 0) && (rel < N_CH*CH_STRIDE) && (ofs_int < 16);
    glob_hit = (rel == N_CH*CH_STRIDE);
    ofs      = ofs_int[3:0];
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign sel[k]      = ch_hit && (ch_int == k);
    assign glob_arm[k] = bus.i_wr && glob_hit && bus.i_data[k];

    pps_div_chan_regs #(
      .DATA_WIDTH  (DATA_WIDTH),
      .PHASE_BYTES (PHASE_BYTES)
    ) u_chan (
      .i_clk_10     (i_clk_10),
      .i_rst        (i_rst),
      .i_sel        (sel[k]),
      .i_wr         (bus.i_wr),
      .i_ofs        (ofs),
      .i_data       (bus.i_data),
      .i_glob_arm   (glob_arm[k]),
      .i_pps_pulse  (i_pps_pulse),
      .o_rdata      (chan_rdata[k]),
      .o_active     (chan_active[k]),
      .o_cfg_update (o_cfg_update[k]),
      .o_pending    (o_pending[k])
    );

    assign o_periodic_true[k*DW +: DW]               = chan_active[k][0 +: DW];
    assign o_div_number[k*DW +: DW]                  = chan_active[k][DW +: DW];
    assign o_phase_us[k*PHASE_BYTES*DW +: PHASE_BYTES*DW] = chan_active[k][2*DW +: PHASE_BYTES*DW];
    assign o_width_us[k*DW +: DW]                    = chan_active[k][(2+PHASE_BYTES)*DW +: DW];
    assign o_start[k*DW +: DW]                       = chan_active[k][(3+PHASE_BYTES)*DW +: DW];
    assign o_stop[k*DW +: DW]                        = chan_active[k][(4+PHASE_BYTES)*DW +: DW];
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_CH; k++)
      if (sel[k])
        rd_mux = chan_rdata[k];
  end

  assign rd_go = bus.i_rd && !bus.i_wr;

  always_ff @(posedge i_clk_10) begin
    if (i_rst) begin
      bus.o_data     <= '0;
      bus.o_rd_valid <= 1'b0;
    end else begin
      bus.o_rd_valid <= rd_go;
      if (rd_go)
        bus.o_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pps_div_regbank.sv
// tb/tb_pps_div_regbank.sv - self-checking bench for pps_div_regbank against a byte-array reference model
module tb_pps_div_regbank;

  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst;
  logic pps;
  always #50 clk = ~clk;

  logic [NC*8-1:0]  per, divn, width, start, stop;
  logic [NC*24-1:0] phase;
  logic [NC-1:0]    upd, pend_o;

  pps_div_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  pps_div_regbank dut (
    .i_clk_10        (clk),
    .i_rst           (rst),
    .bus             (bus),
    .i_pps_pulse     (pps),
    .o_periodic_true (per),
    .o_div_number    (divn),
    .o_phase_us      (phase),
    .o_width_us      (width),
    .o_start         (start),
    .o_stop          (stop),
    .o_cfg_update    (upd),
    .o_pending       (pend_o)
  );

  // Reference state: byte k of a channel is the register at offset k.
  logic [7:0] sh [NC][8];
  logic [7:0] ac [NC][8];
  logic       pd [NC];
  logic       up [NC];
  logic [7:0] exp_data;
  logic       exp_valid;
  int n_err = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic differs(input int k);
    logic d;
    d = 1'b0;
    for (int b = 0; b < 8; b++) if (sh[k][b] != ac[k][b]) d = 1'b1;
    return d;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NC; k++) begin
      for (int b = 0; b < 8; b++) begin
        sh[k][b] = 8'h00;
        ac[k][b] = 8'h00;
      end
      pd[k] = 1'b0;
      up[k] = 1'b0;
    end
    exp_data  = 8'h00;
    exp_valid = 1'b0;
  endfunction

  function automatic void model_step(input logic wr, input logic rd, input logic [7:0] addr,
                                     input logic [7:0] data, input logic p);
    int rel, ch, ofs;
    logic a, nw, ds, c;
    rel = int'(addr) - 'h40;
    ch  = -1;
    ofs = -1;
    if (rel >= 0 && rel < NC*16) begin
      ch  = rel / 16;
      ofs = rel % 16;
    end
    if (rd && !wr) begin
      exp_valid = 1'b1;
      exp_data  = 8'h00;
      if (ch >= 0 && ofs < 8) exp_data = sh[ch][ofs];
      else if (ch >= 0 && ofs == 8) exp_data = {6'b0, differs(ch), pd[ch]};
    end else begin
      exp_valid = 1'b0;
    end
    for (int k = 0; k < NC; k++) begin
      a  = wr && ((ch == k && ofs == 9 && data == 8'h01) || (rel == NC*16 && data[k]));
      nw = wr && ch == k && ofs == 9 && data == 8'h02;
      ds = wr && ch == k && ofs == 9 && data == 8'h00;
      c  = nw || (pd[k] && p && !a && !ds);
      if (c) for (int b = 0; b < 8; b++) ac[k][b] = sh[k][b];
      up[k] = c;
      if (nw || ds || c) pd[k] = 1'b0;
      if (a && !nw) pd[k] = 1'b1;
    end
    if (wr && ch >= 0 && ofs < 8) sh[ch][ofs] = data;
  endfunction

  task automatic check_all();
    logic [NC*8-1:0]  e_per, e_div, e_w, e_st, e_sp;
    logic [NC*24-1:0] e_ph;
    logic [NC-1:0]    e_pd, e_up;
    for (int k = 0; k < NC; k++) begin
      e_per[k*8 +: 8]  = ac[k][0];
      e_div[k*8 +: 8]  = ac[k][1];
      e_ph[k*24 +: 24] = {ac[k][4], ac[k][3], ac[k][2]};
      e_w[k*8 +: 8]    = ac[k][5];
      e_st[k*8 +: 8]   = ac[k][6];
      e_sp[k*8 +: 8]   = ac[k][7];
      e_pd[k]          = pd[k];
      e_up[k]          = up[k];
    end
    chk("pending",  128'(pend_o), 128'(e_pd));
    chk("cfg_upd",  128'(upd),    128'(e_up));
    chk("per_true", 128'(per),    128'(e_per));
    chk("div_num",  128'(divn),   128'(e_div));
    chk("phase",    128'(phase),  128'(e_ph));
    chk("width",    128'(width),  128'(e_w));
    chk("start",    128'(start),  128'(e_st));
    chk("stop",     128'(stop),   128'(e_sp));
    chk("rd_valid", 128'(bus.o_rd_valid), 128'(exp_valid));
    chk("rd_data",  128'(bus.o_data),     128'(exp_data));
  endtask

  task automatic cyc(input logic wr, input logic rd, input logic [7:0] addr,
                     input logic [7:0] data, input logic p);
    bus.i_wr   = wr;
    bus.i_rd   = rd;
    bus.i_addr = addr;
    bus.i_data = data;
    pps        = p;
    @(posedge clk);
    model_step(wr, rd, addr, data, p);
    #1;
    bus.i_wr = 1'b0;
    bus.i_rd = 1'b0;
    pps      = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.i_wr = 1'b0;
    bus.i_rd = 1'b0;
    pps      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    logic [7:0] addr, data;
    bus.i_addr = 8'h00;
    bus.i_data = 8'h00;
    model_reset();

    // Reset, then every mapped channel address reads back zero.
    do_reset();
    for (int a = 'h40; a < 'h80; a++) cyc(1'b0, 1'b1, 8'(a), 8'h00, 1'b0);

    // Channel 1 phase, armed, then PPS.
    cyc(1'b1, 1'b0, 8'h52, 8'h12, 1'b0);
    cyc(1'b1, 1'b0, 8'h53, 8'h34, 1'b0);
    cyc(1'b1, 1'b0, 8'h54, 8'h56, 1'b0);
    cyc(1'b1, 1'b0, 8'h59, 8'h01, 1'b0);
    cyc(1'b0, 1'b1, 8'h58, 8'h00, 1'b0);
    chk("arm_pending_ch1", 128'(pend_o[1]), 128'(1'b1));
    chk("arm_status_ch1", 128'(bus.o_data), 128'(8'h03));
    chk("phase_before_pps", 128'(phase[24 +: 24]), 128'(24'h000000));
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("phase_after_pps", 128'(phase[24 +: 24]), 128'(24'h563412));
    chk("upd_ch1_pulse", 128'(upd), 128'(4'b0010));
    chk("pending_cleared", 128'(pend_o[1]), 128'(1'b0));
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("upd_one_cycle", 128'(upd), 128'(4'b0000));

    // Arm in the same cycle as PPS: commit waits for the next pulse.
    cyc(1'b1, 1'b0, 8'h55, 8'hAA, 1'b0);
    cyc(1'b1, 1'b0, 8'h59, 8'h01, 1'b1);
    chk("arm_pps_nocommit", 128'(width[15:8]), 128'(8'h00));
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("arm_pps_next", 128'(width[15:8]), 128'(8'hAA));

    // Immediate commit on channel 0.
    cyc(1'b1, 1'b0, 8'h41, 8'h05, 1'b0);
    cyc(1'b1, 1'b0, 8'h49, 8'h02, 1'b0);
    chk("now_div_ch0", 128'(divn), 128'(32'h0000_0005));

    // Global arm of channels 0 and 2.
    for (int k = 0; k < NC; k++) cyc(1'b1, 1'b0, 8'(8'h46 + 16*k), 8'(8'hA0 + k), 1'b0);
    cyc(1'b1, 1'b0, 8'h80, 8'h05, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("glob_start", 128'(start), 128'(32'h00A2_00A0));

    // Shadow write in the commit cycle keeps the new value in shadow only.
    cyc(1'b1, 1'b0, 8'h69, 8'h01, 1'b0);
    cyc(1'b1, 1'b0, 8'h67, 8'h3C, 1'b1);
    cyc(1'b0, 1'b1, 8'h68, 8'h00, 1'b0);
    chk("commit_race_status", 128'(bus.o_data), 128'(8'h02));

    // Disarm with PPS, reserved and unmapped writes, immediate commit while pending.
    cyc(1'b1, 1'b0, 8'h79, 8'h01, 1'b0);
    cyc(1'b1, 1'b0, 8'h79, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h4C, 8'h77, 1'b0);
    cyc(1'b1, 1'b0, 8'h81, 8'h33, 1'b0);
    cyc(1'b0, 1'b1, 8'h4C, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h81, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("rd_data_holds", 128'(bus.o_data), 128'(8'h00));
    cyc(1'b1, 1'b0, 8'h71, 8'h99, 1'b0);
    cyc(1'b1, 1'b0, 8'h79, 8'h01, 1'b0);
    cyc(1'b1, 1'b0, 8'h79, 8'h02, 1'b0);

    // Reset while armed cancels the commit.
    cyc(1'b1, 1'b0, 8'h75, 8'h44, 1'b0);
    cyc(1'b1, 1'b0, 8'h79, 8'h01, 1'b0);
    do_reset();
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Random traffic, biased toward mapped addresses and valid commit codes.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(8'h3E, 8'h83));
      data = (addr[3:0] == 4'h9) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, data,
          1'($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
